// File: rtl/async_handshake_tx_if.sv
// Local valid/ready source plus four-phase req/ack peer link.
// master = transmitter side, slave = source and peer side.
interface async_handshake_tx_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  req_out;
    logic                  ack_in;

    modport master (
        input  in_data,
        input  in_valid,
        input  ack_in,
        output in_ready,
        output data_out,
        output req_out
    );

    modport slave (
        output in_data,
        output in_valid,
        output ack_in,
        input  in_ready,
        input  data_out,
        input  req_out
    );
endinterface

// File: rtl/async_handshake_tx.sv
// Four-phase req/ack initiator with ack synchroniser.
// Optional per-phase timeout built when ASYNC_HANDSHAKE_TIMEOUT_EN is defined.
module async_handshake_tx #(
    parameter int DATA_WIDTH     = 8,
    parameter int SYNC_BITS      = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                 clock,
    input  logic                 reset,
    async_handshake_tx_if.master bus,
    output logic                 busy,
    output logic                 timeout
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_REQ,
        ST_RELEASE
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic [SYNC_BITS-1:0]  sync_q;
    logic                  ack_sync;
    logic                  accept;
    logic                  limit;
    logic                  req_q;
    logic [DATA_WIDTH-1:0] data_q;

    if (SYNC_BITS < 2 || TIMEOUT_CYCLES < 2) begin : g_bad_params
        $error("async_handshake_tx: SYNC_BITS and TIMEOUT_CYCLES must be >= 2");
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_BITS-2:0], bus.ack_in};
        end
    end

    assign ack_sync = sync_q[SYNC_BITS-1];

    assign bus.in_ready = (state_q == ST_IDLE) && !reset;
    assign accept       = bus.in_valid && bus.in_ready;
    assign busy         = (state_q != ST_IDLE);
    assign bus.req_out  = req_q;
    assign bus.data_out = data_q;

    // Ack beats the phase limit when both land on the same cycle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                state_d = ST_REQ;
            end
            ST_REQ: begin
                if (ack_sync || limit) begin
                    state_d = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                if (!ack_sync || limit) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            req_q   <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= (state_d == ST_REQ);
            if (accept) begin
                data_q <= bus.in_data;
            end
        end
    end

`ifdef ASYNC_HANDSHAKE_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] cnt_q;
    logic             tmo_fire;
    logic             tmo_q;

    assign limit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    assign tmo_fire = limit &&
                      (((state_q == ST_REQ) && !ack_sync) ||
                       ((state_q == ST_RELEASE) && ack_sync));

    // Any state change restarts the count, covering REQ and RELEASE entry.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (state_d != state_q) begin
            cnt_q <= '0;
        end else if (state_q == ST_REQ || state_q == ST_RELEASE) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            tmo_q <= 1'b0;
        end else begin
            tmo_q <= tmo_fire;
        end
    end

    assign timeout = tmo_q;
`else
    assign limit   = 1'b0;
    assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_async_handshake_tx.sv
// Scoreboard bench for async_handshake_tx: SYNC_BITS=2 and SYNC_BITS=3 instances.
// Timeout scenario follows ASYNC_HANDSHAKE_TIMEOUT_EN.
module tb_async_handshake_tx;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    async_handshake_tx_if #(.DATA_WIDTH(8)) bus0 ();
    async_handshake_tx_if #(.DATA_WIDTH(8)) bus1 ();

    logic busy0, tmo0, busy1, tmo1;
    logic loopback = 1'b0;
    logic ack_drv  = 1'b0;
    logic ack1_drv = 1'b0;

    assign bus0.ack_in = loopback ? bus0.req_out : ack_drv;
    assign bus1.ack_in = ack1_drv;

    async_handshake_tx #(
        .DATA_WIDTH(8), .SYNC_BITS(2), .TIMEOUT_CYCLES(16)
    ) u0 (
        .clock(clock), .reset(reset), .bus(bus0.master),
        .busy(busy0), .timeout(tmo0)
    );

    async_handshake_tx #(
        .DATA_WIDTH(8), .SYNC_BITS(3), .TIMEOUT_CYCLES(16)
    ) u1 (
        .clock(clock), .reset(reset), .bus(bus1.master),
        .busy(busy1), .timeout(tmo1)
    );

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    logic [7:0] exp_q[$];
    logic [7:0] sb_exp;
    logic [7:0] held = 8'h00;
    logic req_prev = 1'b0;

    always @(posedge clock) cyc++;

    // Scoreboard: each rising req_out must present the next accepted word
    always begin
        @(posedge clock);
        #2;
        if (bus0.req_out === 1'b1 && req_prev !== 1'b1) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL sb_pop: req rose with data_out=%h, nothing expected", bus0.data_out);
                held = 8'hxx;
            end else begin
                sb_exp = exp_q.pop_front();
                held = sb_exp;
                if (bus0.data_out !== sb_exp) begin
                    miscompares++;
                    $display("FAIL sb_data: got %h want %h", bus0.data_out, sb_exp);
                end
            end
        end else if (bus0.req_out === 1'b1) begin
            vectors++;
            if (bus0.data_out !== held) begin
                miscompares++;
                $display("FAIL hold: data_out %h want %h while req high", bus0.data_out, held);
            end
        end
        req_prev = bus0.req_out;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send(input logic [7:0] w, output int acc);
        logic rdy;
        rdy = 1'b0;
        bus0.in_data  = w;
        bus0.in_valid = 1'b1;
        for (int n = 0; n < 100; n++) begin
            rdy = bus0.in_ready;
            tick();
            if (rdy) break;
        end
        acc = cyc;
        bus0.in_valid = 1'b0;
        if (rdy) begin
            exp_q.push_back(w);
        end else begin
            vectors++;
            miscompares++;
            $display("FAIL send_wait: in_ready=0 want 1 within 100 cycles");
        end
    endtask

    task automatic wait_idle(input int limit_cycles);
        logic ok;
        ok = 1'b0;
        for (int n = 0; n < limit_cycles; n++) begin
            tick();
            if (bus0.in_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL wait_idle: in_ready=%b want 1", bus0.in_ready);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        vectors++;
        if (bus0.in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_in_ready: got %b want 0", bus0.in_ready);
        end
        vectors++;
        if (bus0.req_out !== 1'b0 || bus1.req_out !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_req: got %b/%b want 0/0", bus0.req_out, bus1.req_out);
        end
        vectors++;
        if (bus0.data_out !== 8'h00) begin
            miscompares++;
            $display("FAIL rst_data: got %h want 00", bus0.data_out);
        end
        vectors++;
        if (busy0 !== 1'b0 || tmo0 !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_busy_tmo: got %b/%b want 0/0", busy0, tmo0);
        end
        reset = 1'b0;
        #1;
        vectors++;
        if (bus0.in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_release_ready: got %b want 1", bus0.in_ready);
        end
        tick();
    endtask

    task automatic test_basic();
        int acc;
        send(8'hA5, acc);
        vectors++;
        if (bus0.data_out !== 8'hA5 || busy0 !== 1'b1 || bus0.in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_accept: data=%h busy=%b rdy=%b want a5/1/0",
                     bus0.data_out, busy0, bus0.in_ready);
        end
        vectors++;
        if (bus0.req_out !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_setup: req=%b want 0", bus0.req_out);
        end
        tick();
        vectors++;
        if (bus0.req_out !== 1'b1) begin
            miscompares++;
            $display("FAIL basic_req_rise: req=%b want 1", bus0.req_out);
        end
        repeat (5) tick();
        ack_drv = 1'b1;
        tick();
        tick();
        vectors++;
        if (bus0.req_out !== 1'b1) begin
            miscompares++;
            $display("FAIL basic_req_early: req=%b want 1 at A+1", bus0.req_out);
        end
        tick();
        vectors++;
        if (bus0.req_out !== 1'b0 || busy0 !== 1'b1) begin
            miscompares++;
            $display("FAIL basic_req_fall: req=%b busy=%b want 0/1 at A+2", bus0.req_out, busy0);
        end
        repeat (4) tick();
        ack_drv = 1'b0;
        tick();
        tick();
        vectors++;
        if (bus0.in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_idle_early: rdy=%b want 0 at B+1", bus0.in_ready);
        end
        tick();
        vectors++;
        if (bus0.in_ready !== 1'b1 || busy0 !== 1'b0 || bus0.data_out !== 8'hA5) begin
            miscompares++;
            $display("FAIL basic_done: rdy=%b busy=%b data=%h want 1/0/a5",
                     bus0.in_ready, busy0, bus0.data_out);
        end
    endtask

    task automatic test_back_to_back();
        int a1, a2;
        loopback = 1'b1;
        send(8'h01, a1);
        send(8'h02, a2);
        vectors++;
        if (a2 - a1 != 8) begin
            miscompares++;
            $display("FAIL b2b_spacing: got %0d cycles want 8", a2 - a1);
        end
        wait_idle(40);
        vectors++;
        if (bus0.data_out !== 8'h02) begin
            miscompares++;
            $display("FAIL b2b_last: data=%h want 02", bus0.data_out);
        end
        loopback = 1'b0;
    endtask

    task automatic test_sync_latency();
        logic ok;
        vectors++;
        if (bus1.in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL sync_ready: rdy=%b want 1", bus1.in_ready);
        end
        bus1.in_data  = 8'h5A;
        bus1.in_valid = 1'b1;
        tick();
        bus1.in_valid = 1'b0;
        vectors++;
        if (bus1.data_out !== 8'h5A || busy1 !== 1'b1) begin
            miscompares++;
            $display("FAIL sync_accept: data=%h busy=%b want 5a/1", bus1.data_out, busy1);
        end
        tick();
        ack1_drv = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            vectors++;
            if (bus1.req_out !== 1'b1) begin
                miscompares++;
                $display("FAIL sync_hold: req=%b want 1 at A+%0d", bus1.req_out, k);
            end
        end
        tick();
        vectors++;
        if (bus1.req_out !== 1'b0) begin
            miscompares++;
            $display("FAIL sync_fall: req=%b want 0 at A+3", bus1.req_out);
        end
        ack1_drv = 1'b0;
        ok = 1'b0;
        for (int n = 0; n < 20; n++) begin
            tick();
            if (bus1.in_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL sync_idle: rdy=%b want 1", bus1.in_ready);
        end
    endtask

    task automatic test_reset_mid_req();
        int acc;
        send(8'h77, acc);
        tick();
        vectors++;
        if (bus0.req_out !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_req_up: req=%b want 1", bus0.req_out);
        end
        reset = 1'b1;
        tick();
        vectors++;
        if (bus0.req_out !== 1'b0 || bus0.data_out !== 8'h00) begin
            miscompares++;
            $display("FAIL mid_rst_out: req=%b data=%h want 0/00", bus0.req_out, bus0.data_out);
        end
        vectors++;
        if (busy0 !== 1'b0 || tmo0 !== 1'b0 || bus0.in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_rst_flags: busy=%b tmo=%b rdy=%b want 0/0/0",
                     busy0, tmo0, bus0.in_ready);
        end
        reset = 1'b0;
        #1;
        vectors++;
        if (bus0.in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_rst_ready: rdy=%b want 1", bus0.in_ready);
        end
        tick();
        loopback = 1'b1;
        send(8'hC3, acc);
        wait_idle(40);
        vectors++;
        if (bus0.data_out !== 8'hC3 || busy0 !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_rst_next: data=%h busy=%b want c3/0", bus0.data_out, busy0);
        end
        loopback = 1'b0;
    endtask

    task automatic test_timeout();
        int acc;
        logic bad;
        logic ok;
        ack_drv = 1'b0;
        send(8'h99, acc);
        tick();
        vectors++;
        if (bus0.req_out !== 1'b1) begin
            miscompares++;
            $display("FAIL tmo_req_up: req=%b want 1", bus0.req_out);
        end
        bad = 1'b0;
`ifdef ASYNC_HANDSHAKE_TIMEOUT_EN
        for (int k = 1; k <= 15; k++) begin
            tick();
            if (bus0.req_out !== 1'b1 || tmo0 !== 1'b0) bad = 1'b1;
        end
        vectors++;
        if (bad) begin
            miscompares++;
            $display("FAIL tmo_wait: req/tmo=%b/%b want 1/0 before limit", bus0.req_out, tmo0);
        end
        tick();
        vectors++;
        if (bus0.req_out !== 1'b0 || tmo0 !== 1'b1) begin
            miscompares++;
            $display("FAIL tmo_fire: req=%b tmo=%b want 0/1", bus0.req_out, tmo0);
        end
        tick();
        vectors++;
        if (tmo0 !== 1'b0 || bus0.in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL tmo_after: tmo=%b rdy=%b want 0/1", tmo0, bus0.in_ready);
        end
        ok = 1'b1;
`else
        for (int k = 1; k <= 120; k++) begin
            tick();
            if (bus0.req_out !== 1'b1 || tmo0 !== 1'b0) bad = 1'b1;
        end
        vectors++;
        if (bad) begin
            miscompares++;
            $display("FAIL notmo_wait: req/tmo=%b/%b want 1/0 for 120 cycles", bus0.req_out, tmo0);
        end
        ack_drv = 1'b1;
        ok = 1'b0;
        for (int n = 0; n < 20; n++) begin
            tick();
            if (bus0.req_out === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        ack_drv = 1'b0;
        wait_idle(20);
`endif
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL tmo_release: req=%b want 0", bus0.req_out);
        end
    endtask

    task automatic test_stale_ack();
        int acc;
        logic bad;
        ack_drv = 1'b1;
        repeat (4) tick();
        vectors++;
        if (busy0 !== 1'b0 || bus0.in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL stale_idle: busy=%b rdy=%b want 0/1", busy0, bus0.in_ready);
        end
        send(8'h3C, acc);
        vectors++;
        if (bus0.req_out !== 1'b0 || bus0.data_out !== 8'h3C) begin
            miscompares++;
            $display("FAIL stale_setup: req=%b data=%h want 0/3c", bus0.req_out, bus0.data_out);
        end
        tick();
        vectors++;
        if (bus0.req_out !== 1'b1) begin
            miscompares++;
            $display("FAIL stale_req: req=%b want 1", bus0.req_out);
        end
        tick();
        vectors++;
        if (bus0.req_out !== 1'b0 || busy0 !== 1'b1) begin
            miscompares++;
            $display("FAIL stale_req_len: req=%b busy=%b want 0/1", bus0.req_out, busy0);
        end
        bad = 1'b0;
        repeat (6) begin
            tick();
            if (busy0 !== 1'b1 || bus0.in_ready !== 1'b0) bad = 1'b1;
        end
        vectors++;
        if (bad) begin
            miscompares++;
            $display("FAIL stale_release_hold: busy=%b rdy=%b want 1/0", busy0, bus0.in_ready);
        end
        ack_drv = 1'b0;
        tick();
        tick();
        vectors++;
        if (bus0.in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL stale_idle_early: rdy=%b want 0 at B+1", bus0.in_ready);
        end
        tick();
        vectors++;
        if (bus0.in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL stale_done: rdy=%b want 1 at B+2", bus0.in_ready);
        end
    endtask

    initial begin
        reset         = 1'b1;
        bus0.in_data  = 8'h00;
        bus0.in_valid = 1'b0;
        bus1.in_data  = 8'h00;
        bus1.in_valid = 1'b0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_sync_latency();
        test_reset_mid_req();
        test_timeout();
        test_stale_ack();
        tick();
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL sb_leftover: %0d words never presented, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/async_handshake_tx.md
# async_handshake_tx

Initiator side of a four-phase (return-to-zero) req/ack handshake toward a peer in an unrelated clock domain. Accepts a word from a local valid/ready source, holds it stable on `data_out`, drives `req_out`, and completes the cycle on the peer's `ack_in`. `ack_in` passes through an internal multi-flop synchroniser stage before use. It pairs with the input synchronisers used on the receive side of the design.

## Interface
- `DATA_WIDTH`, 8: width of the transferred word.
- `SYNC_BITS`, 2: flops in the `ack_in` synchroniser chain; minimum 2.
- `TIMEOUT_CYCLES`, 1024: wait limit per handshake phase; used only with the timeout feature.

- `clock`  in  1: sole clock, rising edge.
- `reset`  in  1: synchronous, active-high.
- `in_data`  in  DATA_WIDTH: word from the local source.
- `in_valid`  in  1: `in_data` is valid.
- `in_ready`  out  1: block can accept a word.
- `data_out`  out  DATA_WIDTH: word presented to the peer; stable while `req_out` is high.
- `req_out`  out  1: request to the peer, registered.
- `ack_in`  in  1: peer acknowledge, asynchronous.
- `busy`  out  1: a handshake is in progress.
- `timeout`  out  1: one-cycle pulse on a phase timeout.

## Operation
- **Synchroniser.**
  - `ack_sync` is the last stage of a SYNC_BITS-deep shift register clocked by `clock` and fed by `ack_in`.
  - Only `ack_sync` is used internally.
- **States.** IDLE, SETUP, REQ, RELEASE.
  - IDLE: `in_ready`=1. On `in_valid`&&`in_ready`, latch `in_data` into `data_out` and go to SETUP.
  - SETUP: lasts one cycle, which gives the peer one cycle of data setup before `req_out` rises. Then go to REQ.
  - REQ: `req_out`=1. When `ack_sync`=1, go to RELEASE.
  - RELEASE: `req_out`=0. When `ack_sync`=0, go to IDLE.
- **Output decode.**
  - `in_ready` = (state==IDLE) && !`reset`.
  - `busy` = (state!=IDLE).
  - `req_out` is a flop, set on entry to REQ and cleared on exit from REQ.
- **Data hold.** `data_out` changes only on an accepted transfer. It holds its value through SETUP, REQ, RELEASE and IDLE until the next accept.
- **Stale ack.** If `ack_sync`=1 in IDLE or SETUP, it is ignored. REQ still waits for `ack_sync`=1, so a peer that never dropped ack completes REQ immediately.
- **Reset.**
  - Values: state=IDLE, `req_out`=0, `data_out`=0, synchroniser flops=0, `timeout`=0, `busy`=0.
  - `in_ready`=0 while `reset` is high.
  - Reset mid-handshake drops `req_out` on the next edge with no completion. Recovery from the peer's side is the peer's responsibility.
- `in_valid` is ignored outside IDLE. No buffering; the source holds its word until `in_ready`.

## Timing
Accept at edge E0, with `in_valid`=1 and `in_ready`=1 sampled there.
- After E0: `data_out`=word, state=SETUP, `in_ready`=0, `busy`=1.
- After E0+1: `req_out`=1.
- If `ack_in` is first sampled high at edge A, `ack_sync`=1 after edge A+SYNC_BITS-1. `req_out` falls after edge A+SYNC_BITS.
- If `ack_in` is first sampled low at edge B (in RELEASE), the state returns to IDLE and `in_ready`=1 after edge B+SYNC_BITS.
- Minimum turnaround with an instant peer (`ack_in` equal to `req_out` combinationally): 2 + 2×(SYNC_BITS+1) cycles from accept to the next `in_ready`. With SYNC_BITS=2 this is 8 cycles.
- `ack_in` glitches shorter than one clock may be missed. The peer must hold each ack level until it sees the corresponding `req_out` level.

## Configuration
- `ASYNC_HANDSHAKE_TIMEOUT_EN` defined:
  - A phase counter of width $clog2(TIMEOUT_CYCLES) clears on entry to REQ and on entry to RELEASE, and increments each cycle in those states.
  - If the counter reaches TIMEOUT_CYCLES-1 in REQ without `ack_sync`=1: go to RELEASE, drop `req_out`, pulse `timeout`.
  - If it reaches TIMEOUT_CYCLES-1 in RELEASE without `ack_sync`=0: go to IDLE, pulse `timeout`.
  - If the ack condition and the counter limit occur on the same cycle, the ack wins and no pulse is produced.
- Not defined: no counter is built, `timeout` is tied to 0, and REQ/RELEASE wait indefinitely.

## Test plan
- **Basic transfer.** Reset; drive `in_data`=8'hA5, `in_valid`=1 at edge E0. Peer raises `ack_in` 5 cycles after `req_out` rises and drops it 4 cycles after `req_out` falls. Required: `data_out`=8'hA5 after E0; `req_out` high after E0+1; `data_out` unchanged while `req_out`=1; full cycle completes; `in_ready`=1 again.
- **Back-to-back.** Hold `in_valid`=1 with 8'h01 then 8'h02, using a loopback peer with `ack_in`=`req_out`. Required: two transfers, each one accepted; 8-cycle accept-to-ready spacing at SYNC_BITS=2.
- **Sync latency.** SYNC_BITS=3; `ack_in` rises at edge A. Required: `req_out` falls exactly after edge A+3.
- **Reset mid-REQ.** Assert `reset` for 1 cycle while `req_out`=1. Required: after that edge, `req_out`=0, `data_out`=0, `busy`=0, no `timeout`. Next transfer works normally.
- **Timeout (macro on).** TIMEOUT_CYCLES=16; `ack_in` held at 0. Required: `req_out` falls and `timeout` pulses for exactly 1 cycle, 16 cycles after REQ entry. Then state IDLE after `ack_sync`=0 is seen. Without the macro, `req_out` stays high for 100+ cycles and `timeout`=0.
- **Stale ack.** Hold `ack_in`=1 through IDLE, then accept 8'h3C. Required: REQ lasts exactly 1 cycle; RELEASE waits until `ack_in` drops.
